uart_rx_deserializer: RTL and testbench

//  UART receive path: the receive-side counterpart of the TX controller/shift register on the same serial link.

---
 rtl/uart_rx_deserializer.sv | 128 ++++++++++++
 tb/tb_uart_rx_deserializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - 8N1 UART receiver: oversampled framing, held byte with valid/ack, error flags
// Samples every bit at mid-bit from a 2-FF synchronised copy of the line.
module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 rx_serial,
  input  logic                 rx_ack,
  input  logic                 err_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy_rx
);
  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                 sync1_q, rx_s_q;
  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q;
  logic                 armed_q, armed_d;

  // armed_q blocks a held-low line (break) from re-triggering until it has been seen high
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q & ~rx_ack;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q & ~err_clear;
    armed_d   = armed_q | rx_s_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q && armed_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack) ovr_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      sync1_q   <= rx_serial;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      busy_q    <= (state_d != S_IDLE);
      armed_q   <= armed_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy_rx   = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for uart_rx_deserializer
// Expected bytes are queued when a frame is sent and popped once its commit has happened.
module tb_uart_rx_deserializer;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       rx_serial = 1'b1;
  logic       rx_ack = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy_rx;

  int         n_checks = 0;
  int         n_fail = 0;
  int         fe_count = 0;
  logic [7:0] exp_q[$];

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLK(CLK), .reset(reset), .rx_serial(rx_serial), .rx_ack(rx_ack), .err_clear(err_clear),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun), .busy_rx(busy_rx)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (frame_err === 1'b1) fe_count++;

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_serial = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      idle(CPB);
    end
    rx_serial = stop_bit;
    idle(CPB);
    rx_serial = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    idle(1);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_checks++; if ({rx_valid, frame_err, overrun, busy_rx} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {rx_valid, frame_err, overrun, busy_rx}); end
    idle(3);
    reset = 1'b0;
    idle(5);
    n_checks++; if ({rx_valid, busy_rx} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00", {rx_valid, busy_rx}); end
  endtask

  task automatic test_single();
    int lat;
    int fe0;
    logic [7:0] exp;
    fe0 = fe_count;
    lat = -1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int c = 1; c <= 300; c++) begin
          @(posedge CLK); #1;
          if (rx_valid === 1'b1 && lat < 0) lat = c;
        end
      end
    join
    // lat counts edges from the one before the line falls; commit is 2+HALF+9*CPB (+/-1) after the first low edge
    n_checks++; if (lat < 0 || (lat - 1) < 152 || (lat - 1) > 154) begin
      n_fail++; $display("FAIL single_latency: got %0d want 152..154", lat - 1); end
    exp = exp_q.pop_front();
    n_checks++; if (rx_data !== exp) begin n_fail++; $display("FAIL single_data: got %h want %h", rx_data, exp); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rx_valid); end
    n_checks++; if (fe_count !== fe0) begin n_fail++; $display("FAIL single_no_ferr: got %0d want %0d", fe_count, fe0); end
    pulse_ack();
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clears: got %b want 0", rx_valid); end
    pulse_ack();
    n_checks++; if ({rx_valid, rx_data} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL ack_idle_ignored: got %b/%h want 0/a5", rx_valid, rx_data); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_count;
    rx_serial = 1'b0;
    idle(4);
    rx_serial = 1'b1;
    n_checks++; if (busy_rx !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b want 1", busy_rx); end
    idle(20);
    n_checks++; if ({rx_valid, busy_rx} !== 2'b00) begin n_fail++; $display("FAIL glitch_idle: got %b want 00", {rx_valid, busy_rx}); end
    n_checks++; if (fe_count !== fe0) begin n_fail++; $display("FAIL glitch_ferr: got %0d want %0d", fe_count, fe0); end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_count;
    send_frame(8'h3C, 1'b0);
    idle(4);
    n_checks++; if (fe_count !== fe0 + 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d want %0d", fe_count - fe0, 1); end
    n_checks++; if ({rx_valid, rx_data} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL ferr_hold: got %b/%h want 0/a5", rx_valid, rx_data); end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(2);
    exp = exp_q.pop_front();
    n_checks++; if ({rx_valid, overrun, rx_data} !== {2'b10, exp}) begin
      n_fail++; $display("FAIL ovr_first: got %b%b/%h want 10/%h", rx_valid, overrun, rx_data, exp); end
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1);
    idle(2);
    exp = exp_q.pop_front();
    n_checks++; if ({rx_valid, overrun, rx_data} !== {2'b11, exp}) begin
      n_fail++; $display("FAIL ovr_set: got %b%b/%h want 11/%h", rx_valid, overrun, rx_data, exp); end
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    n_checks++; if ({rx_valid, overrun} !== 2'b10) begin n_fail++; $display("FAIL ovr_clear: got %b want 10", {rx_valid, overrun}); end
  endtask

  task automatic test_ack_on_commit();
    logic [7:0] exp;
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(posedge CLK);
        #1 rx_ack = 1'b1;
        @(posedge CLK);
        #1 rx_ack = 1'b0;
      end
    join
    idle(2);
    exp = exp_q.pop_front();
    n_checks++; if ({rx_valid, overrun, rx_data} !== {2'b10, exp}) begin
      n_fail++; $display("FAIL ack_commit: got %b%b/%h want 10/%h", rx_valid, overrun, rx_data, exp); end
  endtask

  task automatic test_break();
    int fe0;
    logic [7:0] exp;
    pulse_ack();
    fe0 = fe_count;
    rx_serial = 1'b0;
    idle(400);
    n_checks++; if (fe_count !== fe0 + 1) begin n_fail++; $display("FAIL break_ferr: got %0d want 1", fe_count - fe0); end
    n_checks++; if ({rx_valid, busy_rx} !== 2'b00) begin n_fail++; $display("FAIL break_idle: got %b want 00", {rx_valid, busy_rx}); end
    rx_serial = 1'b1;
    idle(10);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(2);
    exp = exp_q.pop_front();
    n_checks++; if ({rx_valid, rx_data} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL break_recover: got %b/%h want 1/%h", rx_valid, rx_data, exp); end
  endtask

  task automatic test_mid_reset();
    int fe0;
    logic [7:0] exp;
    fork
      send_frame(8'h0F, 1'b1);
      begin
        repeat (5 * CPB + 8) @(posedge CLK);
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({rx_data, rx_valid, frame_err, overrun, busy_rx} !== 12'h000) begin
          n_fail++; $display("FAIL midreset_outputs: got %h/%b%b%b%b want 00/0000",
                             rx_data, rx_valid, frame_err, overrun, busy_rx); end
      end
    join
    idle(2);
    reset = 1'b0;
    idle(20);
    fe0 = fe_count;
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1);
    idle(2);
    exp = exp_q.pop_front();
    n_checks++; if ({rx_valid, overrun, rx_data} !== {2'b10, exp}) begin
      n_fail++; $display("FAIL midreset_recover: got %b%b/%h want 10/%h", rx_valid, overrun, rx_data, exp); end
    n_checks++; if (fe_count !== fe0) begin n_fail++; $display("FAIL midreset_ferr: got %0d want %0d", fe_count, fe0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ack_on_commit();
    test_break();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
